// File: rtl/cache_types_pkg.sv
// ----------------------------------------------------------------------------
// cache_types_pkg
//   Shared types and sizing for the cache <-> burst-memory adaptor.
//   LINE_W  : cache line width in bits
//   BURST_W : memory beat width in bits
//   ADDR_W  : byte address width
//   BEATS   : beats per line (LINE_W / BURST_W)
//   adaptor_state_t : adaptor FSM state encoding
// ----------------------------------------------------------------------------
package cache_types_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// ----------------------------------------------------------------------------
// cacheline_adaptor
//   Memory-side responder for the cache pmem interface. Each line read or
//   write is turned into a BEATS x BURST_W burst towards the memory model,
//   and a single-cycle resp_o is returned once the whole line has moved.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-low reset
//   read_i/write_i  : line request from the cache (write wins if both)
//   address_i       : line address, latched at accept
//   line_i          : line to write, latched at accept
//   line_o          : assembled read line, valid while resp_o=1; held until
//                     the first beat of the next read
//   resp_o          : one-cycle transaction-complete pulse
//   address_o       : latched address with the in-line offset bits cleared
//   read_o/write_o  : burst request towards memory
//   burst_o         : current write beat (zero outside WRITE)
//   burst_i, resp_i : read beat and per-beat strobe from memory
//   state_o         : FSM state, for observation only
//
// Handshake: memory acknowledges one beat per cycle in which resp_i=1 while
// read_o or write_o is high; there is no ready/stall back-pressure toward
// memory, and the cache must hold off new requests until resp_o.
//
// Configuration
//   CACHELINE_ADAPTOR_PERF_CNT_EN : adds rd_cnt_o, wr_cnt_o, stall_cnt_o.
// ----------------------------------------------------------------------------
module cacheline_adaptor
  import cache_types_pkg::*;
#(
  parameter int LINE_W  = cache_types_pkg::LINE_W,
  parameter int BURST_W = cache_types_pkg::BURST_W,
  parameter int ADDR_W  = cache_types_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i,
`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  output logic [31:0]        rd_cnt_o,
  output logic [31:0]        wr_cnt_o,
  output logic [31:0]        stall_cnt_o,
`endif
  output adaptor_state_t     state_o
);

  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_t      state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   rd_buf_q;   // read assembly; also the line_o source
  logic [LINE_W-1:0]   wr_buf_q;   // write data; kept apart so line_o survives writes
  logic [ADDR_W-1:0]   addr_q;

  // Main FSM. Beats are counted only in READ/WRITE, so strobes arriving in
  // IDLE or DONE are dropped. A burst cannot be aborted by the requester.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_buf_q <= '0;
      wr_buf_q <= '0;
      addr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (write_i) begin
            addr_q   <= {address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            wr_buf_q <= line_i;
            state_q  <= ST_WRITE;
          end else if (read_i) begin
            addr_q   <= {address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            state_q  <= ST_READ;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            rd_buf_q[int'(cnt_q)*BURST_W +: BURST_W] <= burst_i;
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // All outputs decode registered state only; nothing passes from inputs.
  assign read_o    = (state_q == ST_READ);
  assign write_o   = (state_q == ST_WRITE);
  assign resp_o    = (state_q == ST_DONE);
  assign address_o = addr_q;
  assign line_o    = rd_buf_q;
  assign burst_o   = (state_q == ST_WRITE) ? wr_buf_q[int'(cnt_q)*BURST_W +: BURST_W]
                                           : '0;
  assign state_o   = state_q;

`ifdef CACHELINE_ADAPTOR_PERF_CNT_EN
  logic        is_wr_q;  // kind of the transaction in flight
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      is_wr_q     <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      // In IDLE write_i alone decides the kind, mirroring write priority.
      if (state_q == ST_IDLE) begin
        is_wr_q <= write_i;
      end
      if (state_q == ST_DONE) begin
        if (is_wr_q) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
      end
      if ((state_q == ST_READ || state_q == ST_WRITE) && !resp_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
